data_mem_arbiter: RTL

Two-port arbiter and sequencer for the single-port data RAM. It shares the RAM between the CPU load/store port (port 0) and a secondary master such as a debug/DMA engine (port 1). It converts MARS-style byte addresses to RAM word addresses, sequences each access through a fixed issue/wait/respond FSM, and returns a one-cycle acknowledge so that the CPU can stall on it. It sits between the CPU datapath/secondary master and the `data_memory` instance.

---
 rtl/data_mem_arb_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 21 ++
 rtl/data_mem_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data RAM arbiter.
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1000_0000;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational 2-way grant picker.
// DATA_MEM_ARB_FIXED_PRIO_EN selects fixed CPU priority; otherwise round-robin.
module rr_arbiter2
  import data_mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_o
);

`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
  // CPU always wins; the last-served input has no meaning here
  logic unused_last;
  assign unused_last = last_i;
  assign gnt_o = req_i[PORT_CPU] ? PORT_CPU : (req_i[PORT_AUX] ? PORT_AUX : PORT_CPU);
`else
  // Contention goes to the port not served last; otherwise the sole requester
  assign gnt_o = (&req_i) ? ~last_i : req_i[PORT_AUX];
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer for the single-port data RAM.
// Optional build macro: DATA_MEM_ARB_FIXED_PRIO_EN (fixed CPU priority, no last-served pointer).
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 12,
  parameter int          DATA_WIDTH  = 32,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          RAM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  wren0,
  input  logic                  wren1,
  input  logic [31:0]           addr0,
  input  logic [31:0]           addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  err0,
  output logic                  err1,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  busy
);

  localparam logic [32:0] WIN_BYTES = 33'd4 << ADDR_WIDTH;
  localparam logic [1:0]  WAIT_INIT = 2'(RAM_LATENCY - 1);

  arb_state_t state_q, state_d;
  logic                  win_q, wren_q, oow_q, busy_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata0_q, rdata1_q;
  logic [1:0]            cnt_q;
  logic                  ack0_q, ack1_q, err0_q, err1_q;
  logic                  gnt, last_srv;

  rr_arbiter2 u_arb (
    .req_i  ({req1, req0}),
    .last_i (last_srv),
    .gnt_o  (gnt)
  );

  // Winner's request fields and byte-to-word translation
  logic [31:0] sel_addr, off;
  logic        sel_wren, sel_oow;
  logic [DATA_WIDTH-1:0] sel_wdata;
  assign sel_addr  = gnt ? addr1  : addr0;
  assign sel_wren  = gnt ? wren1  : wren0;
  assign sel_wdata = gnt ? wdata1 : wdata0;
  assign off       = sel_addr - BASE_ADDR;
  assign sel_oow   = (sel_addr < BASE_ADDR) || ({1'b0, off} >= WIN_BYTES);

`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
  assign last_srv = PORT_AUX;
`else
  logic last_q;
  // Last-served pointer; reset value makes the CPU port next in line
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   last_q <= PORT_AUX;
    else if (state_q == S_RESP) last_q <= win_q;
  end
  assign last_srv = last_q;
`endif

  // Next-state decode: in-window reads detour through WAIT
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req0 || req1) state_d = S_ACCESS;
      S_ACCESS: state_d = (!wren_q && !oow_q) ? S_WAIT : S_RESP;
      S_WAIT:   if (cnt_q == 2'd0) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register, request latch, wait counter and registered responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      win_q    <= PORT_CPU;
      wren_q   <= 1'b0;
      oow_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= 2'd0;
      busy_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      case (state_q)
        S_IDLE: if (req0 || req1) begin
          win_q   <= gnt;
          wren_q  <= sel_wren;
          wdata_q <= sel_wdata;
          addr_q  <= off[ADDR_WIDTH+1:2];
          oow_q   <= sel_oow;
        end
        S_ACCESS: begin
          cnt_q <= WAIT_INIT;
          if (!wren_q && oow_q) begin
            if (win_q == PORT_AUX) rdata1_q <= '0;
            else                   rdata0_q <= '0;
          end
        end
        S_WAIT: begin
          if (cnt_q == 2'd0) begin
            if (win_q == PORT_AUX) rdata1_q <= ram_q;
            else                   rdata0_q <= ram_q;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        default: ;
      endcase
      if (state_d == S_RESP) begin
        if (win_q == PORT_AUX) begin
          ack1_q <= 1'b1;
          err1_q <= oow_q;
        end else begin
          ack0_q <= 1'b1;
          err0_q <= oow_q;
        end
      end
    end
  end

  // RAM strobes decoded from state; write only in ACCESS and only in-window
  always_comb begin
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    if (state_q == S_ACCESS) begin
      ram_address = addr_q;
      ram_data    = wdata_q;
      ram_wren    = wren_q & ~oow_q;
    end else if (state_q == S_WAIT) begin
      ram_address = addr_q;
    end
  end

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign err0   = err0_q;
  assign err1   = err1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign busy   = busy_q;

endmodule
